// File: rtl/register_rename_ckpt.sv
// Single-issue register rename with per-physical ready/tag tracking and a ring of
// branch checkpoints for one-cycle mispredict recovery. Optional macro: RENAME_ZERO_REG_EN.
module register_rename_ckpt #(
    parameter int NUM_LOG_REGS = 32,
    parameter int NUM_PHY_REGS = 64,
    parameter int NUM_CKPT     = 4,
    parameter int ROB_TAG_W    = 6,
    localparam int LW = $clog2(NUM_LOG_REGS),
    localparam int PW = $clog2(NUM_PHY_REGS),
    localparam int CW = $clog2(NUM_CKPT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_valid,
    input  logic [LW-1:0]        dec_rs_addr,
    input  logic [LW-1:0]        dec_rt_addr,
    input  logic [LW-1:0]        dec_rw_addr,
    input  logic                 dec_uses_rw,
    input  logic                 dec_is_branch,
    input  logic [ROB_TAG_W-1:0] dec_rob_tag,
    output logic                 ren_ready,
    output logic [PW-1:0]        rs_phy,
    output logic [PW-1:0]        rt_phy,
    output logic                 rs_ready,
    output logic                 rt_ready,
    output logic [ROB_TAG_W-1:0] rs_tag,
    output logic [ROB_TAG_W-1:0] rt_tag,
    output logic [PW-1:0]        rw_phy,
    output logic [PW-1:0]        rw_old_phy,
    output logic [CW-1:0]        ckpt_id,
    input  logic                 wb_en,
    input  logic [PW-1:0]        wb_phy,
    input  logic                 commit_free_en,
    input  logic [PW-1:0]        commit_free_phy,
    input  logic                 br_resolve_en,
    input  logic                 br_mispredict,
    output logic [PW:0]          free_count,
    output logic [CW:0]          ckpt_count
);

    localparam logic [CW:0] CNT_FULL = (CW+1)'(NUM_CKPT);

    logic [NUM_LOG_REGS-1:0][PW-1:0]                ren_map_q, ren_map_nxt;
    logic [NUM_PHY_REGS-1:0]                        free_q, free_nxt, ready_q;
    logic [NUM_PHY_REGS-1:0][ROB_TAG_W-1:0]         tag_q;
    logic [NUM_CKPT-1:0][NUM_LOG_REGS-1:0][PW-1:0]  ck_map_q;
    logic [NUM_CKPT-1:0][NUM_PHY_REGS-1:0]          ck_free_q;
    logic [CW-1:0]                                  wr_ptr_q, rd_ptr_q;
    logic [CW:0]                                    cnt_q;

    logic [PW-1:0]           alloc_phy;
    logic [PW:0]             free_cnt;
    logic                    need_alloc, fire, do_alloc, take_ckpt, mispredict, correct;
    logic [NUM_PHY_REGS-1:0] alloc_mask, commit_mask, wb_mask;

    // Lowest-index free register wins.
    always_comb begin
        alloc_phy = '0;
        for (int i = NUM_PHY_REGS-1; i >= 0; i--)
            if (free_q[i]) alloc_phy = PW'(i);
    end

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < NUM_PHY_REGS; i++)
            free_cnt = free_cnt + {{PW{1'b0}}, free_q[i]};
    end

`ifdef RENAME_ZERO_REG_EN
    assign need_alloc = dec_uses_rw & (dec_rw_addr != '0);
`else
    assign need_alloc = dec_uses_rw;
`endif

    assign ren_ready  = ~(need_alloc & (free_cnt == '0))
                      & ~(dec_is_branch & (cnt_q == CNT_FULL))
                      & ~(br_resolve_en & br_mispredict);
    assign fire       = dec_valid & ren_ready;
    assign do_alloc   = fire & need_alloc;
    assign take_ckpt  = fire & dec_is_branch;
    assign mispredict = br_resolve_en &  br_mispredict & (cnt_q != '0);
    assign correct    = br_resolve_en & ~br_mispredict & (cnt_q != '0);

    always_comb begin
        alloc_mask  = do_alloc       ? (NUM_PHY_REGS'(1) << alloc_phy)       : '0;
        commit_mask = commit_free_en ? (NUM_PHY_REGS'(1) << commit_free_phy) : '0;
        wb_mask     = wb_en          ? (NUM_PHY_REGS'(1) << wb_phy)          : '0;
`ifdef RENAME_ZERO_REG_EN
        // p0 is permanently owned by r0 and must never re-enter the free pool.
        commit_mask[0] = 1'b0;
`endif
    end

    // State as it stands after this cycle's allocation; a branch checkpoints exactly this.
    always_comb begin
        ren_map_nxt = ren_map_q;
        if (do_alloc) ren_map_nxt[dec_rw_addr] = alloc_phy;
        free_nxt = (free_q & ~alloc_mask) | commit_mask;
    end

    // In zero-reg mode r0/p0 need no muxing: p0 is never allocated, so it stays mapped,
    // ready and tag 0 on its own.
    assign rs_phy     = ren_map_q[dec_rs_addr];
    assign rt_phy     = ren_map_q[dec_rt_addr];
    assign rs_ready   = ready_q[rs_phy] | (wb_en & (wb_phy == rs_phy));
    assign rt_ready   = ready_q[rt_phy] | (wb_en & (wb_phy == rt_phy));
    assign rs_tag     = tag_q[rs_phy];
    assign rt_tag     = tag_q[rt_phy];
    assign rw_phy     = alloc_phy;
    assign rw_old_phy = ren_map_q[dec_rw_addr];
    assign ckpt_id    = wr_ptr_q;
    assign free_count = free_cnt;
    assign ckpt_count = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LOG_REGS; i++) ren_map_q[i] <= PW'(i);
            free_q    <= {{(NUM_PHY_REGS-NUM_LOG_REGS){1'b1}}, {NUM_LOG_REGS{1'b0}}};
            ready_q   <= '1;
            tag_q     <= '0;
            ck_map_q  <= '0;
            ck_free_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            ready_q <= (ready_q & ~alloc_mask) | wb_mask;
            if (do_alloc) tag_q[alloc_phy] <= dec_rob_tag;
            // Registers released at commit stay released whichever checkpoint is restored.
            for (int c = 0; c < NUM_CKPT; c++) ck_free_q[c] <= ck_free_q[c] | commit_mask;
            if (mispredict) begin
                ren_map_q <= ck_map_q[rd_ptr_q];
                free_q    <= ck_free_q[rd_ptr_q] | commit_mask;
                wr_ptr_q  <= rd_ptr_q;
                cnt_q     <= '0;
            end else begin
                ren_map_q <= ren_map_nxt;
                free_q    <= free_nxt;
                if (take_ckpt) begin
                    ck_map_q[wr_ptr_q]  <= ren_map_nxt;
                    ck_free_q[wr_ptr_q] <= free_nxt;
                    wr_ptr_q            <= wr_ptr_q + 1'b1;
                end
                if (correct) rd_ptr_q <= rd_ptr_q + 1'b1;
                cnt_q <= cnt_q + {{CW{1'b0}}, take_ckpt} - {{CW{1'b0}}, correct};
            end
        end
    end

endmodule

// File: tb/tb_register_rename_ckpt.sv
// Directed bench for register_rename_ckpt: reset, allocation, stalls, bypass,
// checkpoint ring and mispredict recovery, with hand-computed expectations.
module tb_register_rename_ckpt;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dec_valid, dec_uses_rw, dec_is_branch;
    logic [4:0] dec_rs_addr, dec_rt_addr, dec_rw_addr;
    logic [5:0] dec_rob_tag;
    logic       ren_ready, rs_ready, rt_ready;
    logic [5:0] rs_phy, rt_phy, rw_phy, rw_old_phy, rs_tag, rt_tag;
    logic [1:0] ckpt_id;
    logic       wb_en, commit_free_en, br_resolve_en, br_mispredict;
    logic [5:0] wb_phy, commit_free_phy;
    logic [6:0] free_count;
    logic [2:0] ckpt_count;

    int checks = 0;
    int errors = 0;

    register_rename_ckpt dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_rs_addr(dec_rs_addr), .dec_rt_addr(dec_rt_addr),
        .dec_rw_addr(dec_rw_addr), .dec_uses_rw(dec_uses_rw), .dec_is_branch(dec_is_branch),
        .dec_rob_tag(dec_rob_tag), .ren_ready(ren_ready),
        .rs_phy(rs_phy), .rt_phy(rt_phy), .rs_ready(rs_ready), .rt_ready(rt_ready),
        .rs_tag(rs_tag), .rt_tag(rt_tag), .rw_phy(rw_phy), .rw_old_phy(rw_old_phy),
        .ckpt_id(ckpt_id), .wb_en(wb_en), .wb_phy(wb_phy),
        .commit_free_en(commit_free_en), .commit_free_phy(commit_free_phy),
        .br_resolve_en(br_resolve_en), .br_mispredict(br_mispredict),
        .free_count(free_count), .ckpt_count(ckpt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dec_valid = 0; dec_uses_rw = 0; dec_is_branch = 0;
        dec_rs_addr = 0; dec_rt_addr = 0; dec_rw_addr = 0; dec_rob_tag = 0;
        wb_en = 0; wb_phy = 0; commit_free_en = 0; commit_free_phy = 0;
        br_resolve_en = 0; br_mispredict = 0;
    endtask

    task automatic offer(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rw,
                         input logic uses, input logic br, input logic [5:0] tag);
        dec_valid = 1; dec_rs_addr = rs; dec_rt_addr = rt; dec_rw_addr = rw;
        dec_uses_rw = uses; dec_is_branch = br; dec_rob_tag = tag;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        idle();
        rst = 1;
        #1;
        chk("arst_free_count", free_count, 32);
        chk("arst_ckpt_count", ckpt_count, 0);
        rst = 0;
    endtask

    initial begin
        idle();
        dec_rs_addr = 3; dec_rt_addr = 4;
        #12 rst = 0;
        #1;
        chk("rst_ren_ready", ren_ready, 1);
        chk("rst_free_count", free_count, 32);
        chk("rst_ckpt_count", ckpt_count, 0);
        chk("rst_ckpt_id", ckpt_id, 0);
        chk("rst_rw_phy", rw_phy, 32);
        chk("rst_rs_phy", rs_phy, 3);
        chk("rst_rt_phy", rt_phy, 4);
        chk("rst_rs_ready", rs_ready, 1);
        chk("rst_rs_tag", rs_tag, 0);

        // First rename: r3, r4 -> r5
        offer(3, 4, 5, 1, 0, 9);
        #1;
        chk("t1_rs_phy", rs_phy, 3);
        chk("t1_rt_phy", rt_phy, 4);
        chk("t1_rt_ready", rt_ready, 1);
        chk("t1_rw_phy", rw_phy, 32);
        chk("t1_rw_old_phy", rw_old_phy, 5);
        step();
        idle(); dec_rs_addr = 5;
        #1;
        chk("t1_map5", rs_phy, 32);
        chk("t1_ready32", rs_ready, 0);
        chk("t1_tag32", rs_tag, 9);
        chk("t1_free_count", free_count, 31);
        chk("t1_next_alloc", rw_phy, 33);

        // Writeback bypass on the same cycle
        wb_en = 1; wb_phy = 32;
        #1;
        chk("byp_rs_ready", rs_ready, 1);
        step();
        wb_en = 0;
        #1;
        chk("wb_rs_ready", rs_ready, 1);

        // Branch, rename r5 again, mispredict
        offer(0, 0, 0, 0, 1, 0);
        #1;
        chk("br_ckpt_id", ckpt_id, 0);
        step();
        idle();
        #1;
        chk("br_ckpt_count", ckpt_count, 1);
        offer(5, 0, 5, 1, 0, 10);
        #1;
        chk("br_rw_phy", rw_phy, 33);
        chk("br_rw_old", rw_old_phy, 32);
        step();
        idle(); dec_rs_addr = 5;
        #1;
        chk("br_map5", rs_phy, 33);
        chk("br_free_count", free_count, 30);
        offer(5, 0, 6, 1, 0, 11);
        br_resolve_en = 1; br_mispredict = 1;
        #1;
        chk("mp_stall", ren_ready, 0);
        step();
        idle(); dec_rs_addr = 5;
        #1;
        chk("mp_map5", rs_phy, 32);
        chk("mp_ckpt_count", ckpt_count, 0);
        chk("mp_free_count", free_count, 31);
        chk("mp_free33", rw_phy, 33);
        chk("mp_ckpt_id", ckpt_id, 0);
        br_resolve_en = 1;
        step();
        idle();
        #1;
        chk("empty_resolve", ckpt_count, 0);

        // Exhaust the free list
        pulse_reset();
        dec_rs_addr = 5;
        #1;
        chk("arst_map5", rs_phy, 5);
        for (int i = 0; i < 32; i++) begin
            offer(0, 0, 5'((i % 31) + 1), 1, 0, 6'(i));
            #1;
            chk("fill_rw_phy", rw_phy, 32'(32 + i));
            step();
        end
        offer(0, 0, 3, 1, 0, 0);
        #1;
        chk("full_free_count", free_count, 0);
        chk("full_stall", ren_ready, 0);
        dec_uses_rw = 0;
        #1;
        chk("full_no_dest", ren_ready, 1);
        dec_uses_rw = 1; dec_rw_addr = 0;
        #1;
`ifdef RENAME_ZERO_REG_EN
        chk("full_rw0", ren_ready, 1);
`else
        chk("full_rw0", ren_ready, 0);
`endif
        dec_rw_addr = 3;
        commit_free_en = 1; commit_free_phy = 7;
        #1;
        chk("free_same_cycle", ren_ready, 0);
        step();
        commit_free_en = 0;
        #1;
        chk("free_next_ready", ren_ready, 1);
        chk("free_next_rw", rw_phy, 7);
        chk("free_next_count", free_count, 1);
        step();
        idle();
        #1;
        chk("refill_count", free_count, 0);

        // Commit frees landing in a live checkpoint and during the restore
        pulse_reset();
        offer(0, 0, 5, 1, 0, 1); step();
        offer(0, 0, 6, 1, 0, 2); step();
        offer(0, 0, 0, 0, 1, 0);
        #1;
        chk("cf_ckpt_id", ckpt_id, 0);
        step();
        idle(); commit_free_en = 1; commit_free_phy = 5;
        step();
        commit_free_en = 0;
        #1;
        chk("cf_free_count", free_count, 31);
        chk("cf_rw_phy", rw_phy, 5);
        offer(7, 0, 7, 1, 0, 3);
        #1;
        chk("cf_rw_old", rw_old_phy, 7);
        step();
        idle();
        br_resolve_en = 1; br_mispredict = 1;
        commit_free_en = 1; commit_free_phy = 6;
        step();
        idle(); dec_rs_addr = 7; dec_rt_addr = 5;
        #1;
        chk("cf_map7", rs_phy, 7);
        chk("cf_map5", rt_phy, 32);
        chk("cf_restore_cnt", free_count, 32);
        chk("cf_restore_rw", rw_phy, 5);
        chk("cf_ckpt_count", ckpt_count, 0);

        // Fill the checkpoint ring
        for (int i = 0; i < 4; i++) begin
            offer(0, 0, 0, 0, 1, 0);
            #1;
            chk("ring_ckpt_id", ckpt_id, 32'(i));
            step();
        end
        idle();
        #1;
        chk("ring_full", ckpt_count, 4);
        offer(0, 0, 0, 0, 1, 0);
        #1;
        chk("ring_stall", ren_ready, 0);
        br_resolve_en = 1;
        #1;
        chk("ring_stall_resolve", ren_ready, 0);
        step();
        br_resolve_en = 0;
        #1;
        chk("ring_after_res", ckpt_count, 3);
        chk("ring_unstall", ren_ready, 1);
        chk("ring_id_wrap", ckpt_id, 0);
        step();
        idle();
        #1;
        chk("ring_refull", ckpt_count, 4);
        br_resolve_en = 1;
        step();
        offer(0, 0, 0, 0, 1, 0);
        #1;
        chk("ring_both_ready", ren_ready, 1);
        step();
        idle();
        #1;
        chk("ring_both_count", ckpt_count, 3);
        chk("ring_both_id", ckpt_id, 2);
        br_resolve_en = 1; br_mispredict = 1;
        step();
        idle();
        #1;
        chk("ring_mp_id", ckpt_id, 3);
        chk("ring_mp_count", ckpt_count, 0);
        chk("ring_mp_free", free_count, 32);

        // Destination r0
        offer(0, 0, 0, 1, 0, 4);
        #1;
        chk("r0_ready", ren_ready, 1);
        step();
        idle();
        #1;
`ifdef RENAME_ZERO_REG_EN
        chk("r0_free_count", free_count, 32);
        chk("r0_map", rs_phy, 0);
        chk("r0_src_ready", rs_ready, 1);
        chk("r0_src_tag", rs_tag, 0);
`else
        chk("r0_free_count", free_count, 31);
        chk("r0_map", rs_phy, 5);
        chk("r0_src_ready", rs_ready, 0);
        chk("r0_src_tag", rs_tag, 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
